// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - arbitrates the shared single-port memory between the fetch and data ports
// Round-robin grant, address check before start, read timeout, one-cycle done/error pulse per access.
module memory_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int TIMEOUT       = 15,
  parameter int TIMEOUT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_request,
  input  logic [WORD_SIZE-1:0] if_address,
  output logic                 if_done,
  output logic                 if_error,
  output logic [WORD_SIZE-1:0] if_read_data,
  input  logic                 dm_request,
  input  logic                 dm_write_enabled,
  input  logic [WORD_SIZE-1:0] dm_address,
  input  logic [WORD_SIZE-1:0] dm_write_data,
  output logic                 dm_done,
  output logic                 dm_error,
  output logic [WORD_SIZE-1:0] dm_read_data,
  output logic                 mem_start,
  output logic                 mem_write_enabled,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_input_data,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_output_data,
  input  logic                 mem_err_invalid_address,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] LP_TIMEOUT = TIMEOUT_WIDTH'(TIMEOUT);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_last_dm;
  logic                     r_gnt_dm;
  logic [TIMEOUT_WIDTH-1:0] r_count;
  logic [TIMEOUT_WIDTH-1:0] w_count_inc;
  logic                     w_grant_if;
  logic                     w_grant_dm;
  logic                     w_fail;
  logic                     w_capture;
  logic                     w_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant_if  = 1'b0;
    w_grant_dm  = 1'b0;
    w_fail      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_count_inc = r_count + 1'b1;
    case (r_state)
      S_IDLE: begin
        // On a tie the port that did not win last time gets the grant.
        if (if_request && (!dm_request || r_last_dm)) w_grant_if = 1'b1;
        else if (dm_request)                          w_grant_dm = 1'b1;
        if (w_grant_if || w_grant_dm) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (mem_err_invalid_address) begin
          w_next = S_DONE;
          w_fail = 1'b1;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (mem_write_enabled) begin
          w_next = S_DONE;
        end else if (mem_valid) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (w_count_inc == LP_TIMEOUT) begin
          w_next    = S_DONE;
          w_fail    = 1'b1;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_dm         <= 1'b1;
      r_gnt_dm          <= 1'b0;
      r_count           <= '0;
      if_done           <= 1'b0;
      if_error          <= 1'b0;
      if_read_data      <= '0;
      dm_done           <= 1'b0;
      dm_error          <= 1'b0;
      dm_read_data      <= '0;
      mem_start         <= 1'b0;
      mem_write_enabled <= 1'b0;
      mem_address       <= '0;
      mem_input_data    <= '0;
      busy              <= 1'b0;
    end else begin
      busy      <= (w_next != S_IDLE);
      mem_start <= (w_next == S_ISSUE);
      if_done   <= 1'b0;
      if_error  <= 1'b0;
      dm_done   <= 1'b0;
      dm_error  <= 1'b0;

      if (w_grant_if) begin
        r_gnt_dm          <= 1'b0;
        r_last_dm         <= 1'b0;
        mem_address       <= if_address;
        mem_input_data    <= '0;
        mem_write_enabled <= 1'b0;
      end else if (w_grant_dm) begin
        r_gnt_dm          <= 1'b1;
        r_last_dm         <= 1'b1;
        mem_address       <= dm_address;
        mem_input_data    <= dm_write_data;
        mem_write_enabled <= dm_write_enabled;
      end

      if (r_state == S_ISSUE)     r_count <= '0;
      else if (r_state == S_WAIT) r_count <= w_count_inc;

      if (w_next == S_DONE) begin
        if (r_gnt_dm) begin
          dm_done  <= 1'b1;
          dm_error <= w_fail;
        end else begin
          if_done  <= 1'b1;
          if_error <= w_fail;
        end
      end

      // A timed-out read returns zero rather than stale data.
      if (w_capture || w_timeout) begin
        if (r_gnt_dm) dm_read_data <= w_capture ? mem_output_data : '0;
        else          if_read_data <= w_capture ? mem_output_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
// Includes a small behavioural model of the single-port memory (1024 words).
module tb_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        if_request;
  logic [31:0] if_address;
  logic        if_done;
  logic        if_error;
  logic [31:0] if_read_data;
  logic        dm_request;
  logic        dm_write_enabled;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic        dm_done;
  logic        dm_error;
  logic [31:0] dm_read_data;
  logic        mem_start;
  logic        mem_write_enabled;
  logic [31:0] mem_address;
  logic [31:0] mem_input_data;
  logic        mem_valid;
  logic [31:0] mem_output_data;
  logic        mem_err_invalid_address;
  logic        busy;

  logic        force_invalid;
  logic [31:0] mem [0:1023];
  int          n_checks;
  int          n_errs;

  memory_arbiter #(.WORD_SIZE(32), .TIMEOUT(15), .TIMEOUT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .if_request(if_request), .if_address(if_address), .if_done(if_done),
    .if_error(if_error), .if_read_data(if_read_data),
    .dm_request(dm_request), .dm_write_enabled(dm_write_enabled), .dm_address(dm_address),
    .dm_write_data(dm_write_data), .dm_done(dm_done), .dm_error(dm_error),
    .dm_read_data(dm_read_data),
    .mem_start(mem_start), .mem_write_enabled(mem_write_enabled), .mem_address(mem_address),
    .mem_input_data(mem_input_data), .mem_valid(mem_valid), .mem_output_data(mem_output_data),
    .mem_err_invalid_address(mem_err_invalid_address), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign mem_err_invalid_address = (mem_address >= 32'd1024);

  // Memory model: acts on the cycle where start is high, valid one cycle later for reads.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem_valid       = 1'b0;
    mem_output_data = '0;
    forever begin
      @(posedge clock);
      if (mem_start && mem_write_enabled) mem[mem_address[9:0]] <= mem_input_data;
      mem_valid       <= mem_start && !mem_write_enabled && !force_invalid;
      mem_output_data <= mem[mem_address[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic any_output();
    return |{if_done, if_error, if_read_data, dm_done, dm_error, dm_read_data,
             mem_start, mem_write_enabled, mem_address, mem_input_data, busy};
  endfunction

  task automatic do_access(input string tag, input bit is_if, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input bit exp_err, input int exp_starts,
                           input bit chk_data, input logic [31:0] exp_data);
    int lat;
    int starts;
    bit seen;
    bit other;
    bit busy1;
    @(negedge clock);
    if (is_if) begin
      if_request = 1'b1;
      if_address = addr;
    end else begin
      dm_request       = 1'b1;
      dm_write_enabled = we;
      dm_address       = addr;
      dm_write_data    = wdata;
    end
    lat = 0; starts = 0; seen = 0; other = 0; busy1 = 0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == 1) busy1 = busy;
      if (mem_start) starts++;
      if (is_if ? dm_done : if_done) other = 1'b1;
      if (is_if ? if_done : dm_done) seen = 1'b1;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, is_if ? if_error : dm_error, exp_err);
    check({tag, "_starts"}, starts, exp_starts);
    check({tag, "_other_done"}, other, 0);
    check({tag, "_busy"}, busy1, 1);
    if (chk_data) check({tag, "_data"}, is_if ? if_read_data : dm_read_data, exp_data);
    if_request = 1'b0;
    dm_request = 1'b0;
  endtask

  initial begin
    int  lat;
    int  ndone;
    int  last_done;
    int  d1;
    int  d2;
    logic [3:0] seq;
    logic [31:0] first_if;
    logic [31:0] first_dm;
    n_checks = 0;
    n_errs   = 0;
    force_invalid    = 1'b0;
    reset            = 1'b1;
    if_request       = 1'b0;
    if_address       = '0;
    dm_request       = 1'b0;
    dm_write_enabled = 1'b0;
    dm_address       = '0;
    dm_write_data    = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", any_output(), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_outputs", any_output(), 0);

    do_access("addr_err", 0, 0, 32'd1024, 32'h0, 2, 1, 0, 1, 32'h0);

    // Both ports request together: fetch first, then alternate while both are held.
    @(negedge clock);
    if_request = 1'b1; if_address = 32'd2;
    dm_request = 1'b1; dm_write_enabled = 1'b0; dm_address = 32'd3;
    lat = 0; ndone = 0; seq = '0; last_done = 0; first_if = '0; first_dm = '0;
    while (ndone < 4 && lat < 40) begin
      @(negedge clock);
      lat++;
      if (if_done || dm_done) begin
        ndone++;
        seq = {seq[2:0], dm_done};
        last_done = lat;
        if (ndone == 1) first_if = if_read_data;
        if (ndone == 2) first_dm = dm_read_data;
      end
    end
    if_request = 1'b0;
    dm_request = 1'b0;
    check("arb_order", seq, 4'b0101);
    check("arb_last_cycle", last_done, 19);
    check("arb_if_data", first_if, 32'hA500_0002);
    check("arb_dm_data", first_dm, 32'hA500_0003);

    do_access("wr5", 0, 1, 32'd5, 32'hDEAD_BEEF, 4, 0, 1, 0, 32'h0);
    do_access("rd5", 0, 0, 32'd5, 32'h0, 4, 0, 1, 1, 32'hDEAD_BEEF);

    force_invalid = 1'b1;
    do_access("if_timeout", 1, 0, 32'd7, 32'h0, 18, 1, 1, 1, 32'h0);
    force_invalid = 1'b0;

    // Reset while a data read sits in WAIT.
    @(negedge clock);
    dm_request = 1'b1; dm_write_enabled = 1'b0; dm_address = 32'd5;
    repeat (3) @(negedge clock);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", any_output(), 0);
    dm_request = 1'b0;
    ndone = 0;
    repeat (3) begin
      @(negedge clock);
      if (dm_done || if_done) ndone++;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (dm_done || if_done) ndone++;
    end
    check("reset_no_done", ndone, 0);
    do_access("rd5_after_reset", 0, 0, 32'd5, 32'h0, 4, 0, 1, 1, 32'hDEAD_BEEF);

    // Request held through done is a fresh request in the following IDLE cycle.
    @(negedge clock);
    dm_request = 1'b1; dm_write_enabled = 1'b0; dm_address = 32'd5;
    lat = 0; d1 = 0; d2 = 0;
    while (d2 == 0 && lat < 40) begin
      @(negedge clock);
      lat++;
      if (dm_done) begin
        if (d1 == 0) d1 = lat;
        else         d2 = lat;
      end
    end
    dm_request = 1'b0;
    check("hold_first_done", d1, 4);
    check("hold_second_done", d2, 9);
    check("hold_data", dm_read_data, 32'hDEAD_BEEF);

    repeat (2) @(negedge clock);
    check("final_idle_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sequences the shared single-port `memory` block between the instruction-fetch port (read-only) and the data port (read/write) of the MIPS core.
- Converts each requester's level request into the memory's `start` edge protocol, checks addresses, times out stalled reads, and returns a one-cycle done/error pulse.
- Sits between the fetch/mem pipeline stages and the `memory` instance.

Parameters:
WORD_SIZE, 32, datapath and address width; must match the `memory` instance.
TIMEOUT, 15, WAIT cycles allowed for `mem_valid` on a read before an error is returned.
TIMEOUT_WIDTH, 4, width of the timeout counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
if_request  input  1  fetch read request, held until `if_done`.
if_address  input  WORD_SIZE  fetch word address.
if_done  output  1  one-cycle completion pulse.
if_error  output  1  high with `if_done` on bad address or timeout.
if_read_data  output  WORD_SIZE  read word, valid while `if_done`=1.
dm_request  input  1  data-port request, held until `dm_done`.
dm_write_enabled  input  1  1=write, 0=read.
dm_address  input  WORD_SIZE  data word address.
dm_write_data  input  WORD_SIZE  write word.
dm_done  output  1  one-cycle completion pulse.
dm_error  output  1  high with `dm_done` on bad address or timeout.
dm_read_data  output  WORD_SIZE  read word, valid while `dm_done`=1.
mem_start  output  1  drives `memory.start`.
mem_write_enabled  output  1  drives `memory.write_enabled`.
mem_address  output  WORD_SIZE  drives `memory.address`.
mem_input_data  output  WORD_SIZE  drives `memory.input_data`.
mem_valid  input  1  from `memory.valid`.
mem_output_data  input  WORD_SIZE  from `memory.output_data`.
mem_err_invalid_address  input  1  from `memory.err_invalid_address`.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (asynchronous):
  - state = IDLE; `last_grant` = DATA; timeout counter = 0.
  - Every output is 0, including `mem_*` and both `read_data` buses.
- Handshake:
  - Requester holds `request` and its operands stable until its `done` pulse.
  - Requester must drop `request` in the `done` cycle; a `request` still high in the following IDLE cycle is a new request.
  - Requests are sampled only in IDLE.
- Arbitration (IDLE):
  - One requester high: it is granted.
  - Both high: round-robin; grant goes to the port that is not `last_grant`.
  - `last_grant` updates on every grant.
  - Fetch requests are always reads; `mem_write_enabled` = 0 for fetch.
- FSM:
  - IDLE: on grant, register the granted operands onto `mem_address`, `mem_input_data` and `mem_write_enabled`, then go to CHECK. `mem_start` = 0.
  - CHECK: `mem_*` buses are stable this cycle.
    - If `mem_err_invalid_address`=1, go to DONE with error set. No `start` is issued, so no memory access occurs.
    - Otherwise go to ISSUE.
  - ISSUE: `mem_start` = 1 for exactly one cycle. Clear the counter, then go to WAIT.
  - WAIT: `mem_start` = 0.
    - Write: go to DONE, no error. The write commits on the `start` rising edge.
    - Read with `mem_valid`=1: capture `mem_output_data` into the granted port's `read_data`, then go to DONE.
    - Read with `mem_valid`=0: increment the counter. When counter == TIMEOUT, go to DONE with error set and `read_data` = 0.
  - DONE: granted port's `done`=1 for one cycle, and `error`=1 if flagged. Go to IDLE. The `read_data` register holds its value until the next capture.
- Latency:
  - Request sampled in IDLE cycle k leads to `done` in cycle k+4 (CHECK k+1, ISSUE k+2, WAIT k+3).
  - Address error: `done` in cycle k+2.
  - Next request can be sampled at the earliest in cycle k+5.
- `mem_address`, `mem_input_data` and `mem_write_enabled` stay constant from CHECK through DONE.
- Reset mid-operation:
  - All outputs clear immediately and no `done` is issued.
  - A write whose `mem_start` rise already occurred has committed. Requesters must reissue anything they still need.
- The non-granted requester's outputs stay 0 throughout.

Test Plan:
- Data write 0xDEADBEEF to address 5, then data read of address 5: `dm_done` in k+4 both times with `dm_error`=0; read gives `dm_read_data`=0xDEADBEEF; `mem_start` high exactly 1 cycle per access.
- `if_request` and `dm_request` raised in the same cycle after reset: fetch granted first, data second. With both held continuously, grants alternate IF, DM, IF, DM.
- Data read of address 1024 (MEMORY_SIZE=1024): `dm_done` and `dm_error` high in k+2, `mem_start` never asserted, `dm_read_data`=0.
- Fetch read with `mem_valid` forced to 0: `if_done`=1, `if_error`=1 after 15 WAIT cycles, `if_read_data`=0.
- `reset` asserted during WAIT of a read: all outputs 0 asynchronously, no `done` pulse; after release, a new data read of address 5 completes normally.
- `dm_request` held high through the `dm_done` cycle: a second identical access starts in cycle k+5.
